// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - slews PWM duty toward a target once per PWM period, with ramp-down and brake
// Optional target clamp to MAX_DUTY when PWM_DUTY_RAMP_DUTY_CLAMP_EN is defined.
module pwm_duty_ramp_ctrl #(
    parameter int                DUTY_W   = 11,
    parameter int                STEP_W   = 6,
    parameter logic [DUTY_W-1:0] MAX_DUTY = 11'h7C0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              brake,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [STEP_W-1:0] step,
    input  logic              pwm_synch,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        RAMP_DN = 3'd2,
        HOLD    = 3'd3,
        BRAKE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              at_target_q;
    logic              busy_q;

    logic [DUTY_W-1:0] lim_target;
    logic [DUTY_W-1:0] eff_target;
    logic [DUTY_W-1:0] eff_step;
    logic [DUTY_W-1:0] next_duty;

`ifdef PWM_DUTY_RAMP_DUTY_CLAMP_EN
    assign lim_target = (target_duty > MAX_DUTY) ? MAX_DUTY : target_duty;
`else
    logic unused_max_duty;
    assign unused_max_duty = ^MAX_DUTY;
    assign lim_target      = target_duty;
`endif

    assign eff_target = en ? lim_target : '0;
    assign eff_step   = (step == '0) ? {{(DUTY_W-1){1'b0}}, 1'b1}
                                     : {{(DUTY_W-STEP_W){1'b0}}, step};

    // Compare before add/sub so the update can neither overshoot nor wrap.
    always_comb begin
        next_duty = duty_q;
        if ((state_q == RAMP_UP || state_q == RAMP_DN) && pwm_synch) begin
            if (eff_target > duty_q) begin
                next_duty = (eff_target - duty_q <= eff_step) ? eff_target : duty_q + eff_step;
            end else if (eff_target < duty_q) begin
                next_duty = (duty_q - eff_target <= eff_step) ? eff_target : duty_q - eff_step;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (brake) begin
            state_d = BRAKE;
            duty_d  = '0;
        end else begin
            case (state_q)
                BRAKE: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
                IDLE: begin
                    duty_d = '0;
                    if (en) begin
                        state_d = (eff_target != '0) ? RAMP_UP : HOLD;
                    end
                end
                RAMP_UP, RAMP_DN, HOLD: begin
                    duty_d = next_duty;
                    // Direction follows the target every clock, even between synch pulses.
                    if (next_duty < eff_target) begin
                        state_d = RAMP_UP;
                    end else if (next_duty > eff_target) begin
                        state_d = RAMP_DN;
                    end else if (!en && next_duty == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            at_target_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            at_target_q <= (state_d == HOLD);
            busy_q      <= (state_d == RAMP_UP) || (state_d == RAMP_DN);
        end
    end

    assign duty      = duty_q;
    assign at_target = at_target_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - directed bench for pwm_duty_ramp_ctrl with a per-cycle reference model
module tb_pwm_duty_ramp_ctrl;

    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        brake = 1'b0;
    logic        pwm_synch = 1'b0;
    logic [10:0] target_duty = '0;
    logic [5:0]  step = '0;
    logic [10:0] duty;
    logic        at_target;
    logic        busy;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;

    int m_state = 0;
    int m_duty = 0;
    bit m_valid = 1'b0;

    pwm_duty_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .brake      (brake),
        .target_duty(target_duty),
        .step       (step),
        .pwm_synch  (pwm_synch),
        .duty       (duty),
        .at_target  (at_target),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: signed integer min/max slew, states classified by target vs duty.
    always @(posedge clk) begin : model
        int tgt, s, nd;
        tgt = en ? int'(target_duty) : 0;
`ifdef PWM_DUTY_RAMP_DUTY_CLAMP_EN
        if (tgt > 'h7C0) tgt = 'h7C0;
`endif
        s = (step == 0) ? 1 : int'(step);
        if (rst) begin
            m_state = 0;
            m_duty  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (brake) begin
                m_state = 4;
                m_duty  = 0;
            end else if (m_state == 4) begin
                m_state = 0;
                m_duty  = 0;
            end else if (m_state == 0) begin
                m_duty = 0;
                if (en) m_state = (tgt > 0) ? 1 : 3;
            end else begin
                nd = m_duty;
                if (m_state != 3 && pwm_synch) begin
                    if (tgt > m_duty) nd = (m_duty + s < tgt) ? m_duty + s : tgt;
                    else              nd = (m_duty - s > tgt) ? m_duty - s : tgt;
                end
                m_duty = nd;
                if (nd < tgt)            m_state = 1;
                else if (nd > tgt)       m_state = 2;
                else if (!en && nd == 0) m_state = 0;
                else                     m_state = 3;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model_duty", 32'(duty), 32'(m_duty));
            check("model_state", 32'(state), 32'(m_state));
            check("model_at_target", 32'(at_target), 32'(m_state == 3));
            check("model_busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic synch_pulse();
        ticks(GAP - 1);
        pwm_synch = 1'b1;
        @(negedge clk);
        pwm_synch = 1'b0;
    endtask

    initial begin
        int up_seq[4];
        int dn_seq[3];
        int clamp_exp;
        up_seq = '{32, 64, 96, 100};
        dn_seq = '{60, 20, 0};

        ticks(2);
        check("rst_duty", 32'(duty), 0);
        check("rst_state", 32'(state), 0);
        check("rst_at_target", 32'(at_target), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Ramp up 0 -> 100 in steps of 32
        en = 1'b1; target_duty = 11'd100; step = 6'd32;
        ticks(2);
        check("up_state", 32'(state), 1);
        for (int i = 0; i < 4; i++) begin
            synch_pulse();
            check("up_duty", 32'(duty), 32'(up_seq[i]));
        end
        check("up_hold", 32'(state), 3);
        check("up_at_target", 32'(at_target), 1);

        // Ramp down on disable
        en = 1'b0; step = 6'd40;
        ticks(2);
        check("dn_state", 32'(state), 2);
        for (int i = 0; i < 3; i++) begin
            synch_pulse();
            check("dn_duty", 32'(duty), 32'(dn_seq[i]));
        end
        check("dn_idle", 32'(state), 0);
        check("dn_busy", 32'(busy), 0);

        // Brake mid-ramp
        en = 1'b1; target_duty = 11'd100; step = 6'd32;
        synch_pulse();
        synch_pulse();
        check("brk_pre_duty", 32'(duty), 64);
        ticks(2);
        brake = 1'b1;
        @(negedge clk);
        check("brk_duty", 32'(duty), 0);
        check("brk_state", 32'(state), 4);
        ticks(3);
        brake = 1'b0;
        @(negedge clk);
        check("brk_rel_state", 32'(state), 0);
        @(negedge clk);
        check("brk_reramp_state", 32'(state), 1);
        check("brk_reramp_duty", 32'(duty), 0);

        // Reversal with step 0
        target_duty = 11'd300; step = 6'd50;
        for (int i = 0; i < 4; i++) synch_pulse();
        check("rev_pre_duty", 32'(duty), 200);
        target_duty = 11'd198; step = 6'd0;
        @(negedge clk);
        check("rev_state", 32'(state), 2);
        check("rev_duty", 32'(duty), 200);
        synch_pulse();
        check("rev_duty1", 32'(duty), 199);
        synch_pulse();
        check("rev_duty2", 32'(duty), 198);
        check("rev_hold", 32'(state), 3);

        // Synch coinciding with brake, then absent synch, then reset mid-ramp
        target_duty = 11'd400; step = 6'd10;
        synch_pulse();
        check("sb_pre_duty", 32'(duty), 208);
        ticks(3);
        pwm_synch = 1'b1; brake = 1'b1;
        @(negedge clk);
        pwm_synch = 1'b0; brake = 1'b0;
        check("sb_duty", 32'(duty), 0);
        check("sb_state", 32'(state), 4);
        ticks(2);
        synch_pulse();
        check("nosynch_pre", 32'(duty), 10);
        ticks(50);
        check("nosynch_duty", 32'(duty), 10);
        check("nosynch_state", 32'(state), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_duty", 32'(duty), 0);
        check("mrst_state", 32'(state), 0);
        check("mrst_at_target", 32'(at_target), 0);
        check("mrst_busy", 32'(busy), 0);

        // Full-scale target, clamped or not depending on build
        target_duty = 11'h7FF; step = 6'd63;
        for (int i = 0; i < 36; i++) synch_pulse();
`ifdef PWM_DUTY_RAMP_DUTY_CLAMP_EN
        clamp_exp = 'h7C0;
`else
        clamp_exp = 'h7FF;
`endif
        check("clamp_duty", 32'(duty), 32'(clamp_exp));
        check("clamp_state", 32'(state), 3);

        ticks(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
